skeleton_ram_bist: RTL and testbench

//  On-device test skeleton for a multi-bank single-port BRAM array. It extends the single-RAM skeleton with
//  NUM_BANKS banks and a built-in self-test (BIST) sequencer that fills every bank with a pattern and reads it back.
//  The read-back counts mismatches, and the result is reported to the host through the standard

---
 rtl/skeleton_ram_bist_if.sv | 32 +++
 rtl/skeleton_ram_bist.sv | 204 ++++++++++++++++++++
 tb/tb_skeleton_ram_bist.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skeleton_ram_bist_if.sv
// Host bus of the multi-bank RAM BIST skeleton. The control and data lines run host->DUT;
// the result and status lines run DUT->host.
interface skeleton_ram_bist_if #(
    parameter int BITWIDTH_IN   = 12,
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 30,
    parameter int BITWIDTH_ADR  = 6,
    parameter int BITWIDTH_BANK = 2
);
    logic                     i_en;
    logic                     i_trgg_start_calc;
    logic [1:0]               i_mode;
    logic                     i_rnw;
    logic [BITWIDTH_BANK-1:0] i_bank;
    logic [BITWIDTH_ADR-1:0]  i_adr;
    logic [BITWIDTH_SYS-1:0]  i_data_in;
    logic                     i_fault_inj;
    logic [BITWIDTH_SYS-1:0]  o_data_out;
    logic [BITWIDTH_HEAD-1:0] o_data_head;
    logic                     o_rdy;
    logic [15:0]              o_err_cnt;

    modport master (
        output i_en, i_trgg_start_calc, i_mode, i_rnw, i_bank, i_adr, i_data_in, i_fault_inj,
        input  o_data_out, o_data_head, o_rdy, o_err_cnt
    );

    modport slave (
        input  i_en, i_trgg_start_calc, i_mode, i_rnw, i_bank, i_adr, i_data_in, i_fault_inj,
        output o_data_out, o_data_head, o_rdy, o_err_cnt
    );
endinterface

// File: rtl/skeleton_ram_bist.sv
// Multi-bank single-port RAM skeleton. It supports direct host access and a fill/verify BIST
// sequencer that counts read-back mismatches.
module skeleton_ram_bist #(
    parameter int BITWIDTH_IN   = 12,
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 30,
    parameter int BITWIDTH_ADR  = 6,
    parameter int BITWIDTH_BANK = 2
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst,
    skeleton_ram_bist_if.slave    bus
);
    localparam int NUM_BANKS = 1 << BITWIDTH_BANK;
    localparam int DEPTH     = 1 << BITWIDTH_ADR;
    localparam int KW        = BITWIDTH_BANK + BITWIDTH_ADR;

    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
    localparam logic [KW-1:0] K_LAST = {KW{1'b1}};

    localparam logic [BITWIDTH_HEAD-1:0] HEAD = BITWIDTH_HEAD'({4'd3, 4'(BITWIDTH_BANK),
        6'(BITWIDTH_ADR), 6'(BITWIDTH_ADR), 5'(BITWIDTH_IN), 5'(BITWIDTH_IN)});

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [BITWIDTH_IN-1:0] f_pattern(input logic inv,
                                                         input logic [BITWIDTH_IN-1:0] seed,
                                                         input logic [KW-1:0] k);
        logic [BITWIDTH_IN-1:0] sum;
        sum = seed + BITWIDTH_IN'(k);
        return inv ? ~sum : sum;
    endfunction

    function automatic logic [BITWIDTH_SYS-1:0] f_pad_word(input logic [BITWIDTH_IN-1:0] word);
        return BITWIDTH_SYS'(word) << (BITWIDTH_SYS - BITWIDTH_IN);
    endfunction

    function automatic logic [15:0] f_sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    state_t                   r_state;
    logic [KW-1:0]            r_k;
    logic [BITWIDTH_IN-1:0]   r_seed;
    logic                     r_inv;
    logic [15:0]              r_err_cnt;
    logic                     r_rdy;
    logic [BITWIDTH_SYS-1:0]  r_dout;
    logic                     r_dout_ram;
    logic                     r_cmp_vld;
    logic [BITWIDTH_IN-1:0]   r_exp;
    logic [BITWIDTH_IN-1:0]   r_mem [NUM_BANKS][DEPTH];
    logic [BITWIDTH_IN-1:0]   r_rd_data;

    logic                     w_we;
    logic                     w_re;
    logic [BITWIDTH_BANK-1:0] w_bank;
    logic [BITWIDTH_ADR-1:0]  w_adr;
    logic [BITWIDTH_IN-1:0]   w_wdata;
    logic [BITWIDTH_IN-1:0]   w_din_word;
    logic                     w_is_direct;
    logic                     w_start;
    logic                     w_k_last;
    logic                     w_mismatch;
    logic [BITWIDTH_SYS-1:0]  w_dout;
    logic                     w_unused;

    assign w_din_word  = bus.i_data_in[BITWIDTH_SYS-1 -: BITWIDTH_IN];
    assign w_is_direct = (bus.i_mode == 2'b00) || (bus.i_mode == 2'b11);
    assign w_start     = bus.i_trgg_start_calc && !w_is_direct;
    assign w_k_last    = (r_k == K_LAST);
    assign w_mismatch  = r_cmp_vld && (r_rd_data != r_exp);
    assign w_unused    = ^bus.i_data_in;

    // RAM port arbitration: the host owns the port in IDLE, the sequencer owns it otherwise
    always_comb begin
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_bank  = bus.i_bank;
        w_adr   = bus.i_adr;
        w_wdata = w_din_word;
        if (bus.i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_direct) begin
                        w_we = bus.i_rnw;
                        w_re = !bus.i_rnw;
                    end else begin
                        w_we = 1'b0;
                        w_re = 1'b0;
                    end
                end
                ST_FILL: begin
                    w_we    = 1'b1;
                    w_bank  = r_k[KW-1 -: BITWIDTH_BANK];
                    w_adr   = r_k[BITWIDTH_ADR-1:0];
                    w_wdata = f_pattern(r_inv, r_seed, r_k);
                end
                ST_VERIFY: begin
                    w_re   = 1'b1;
                    w_bank = r_k[KW-1 -: BITWIDTH_BANK];
                    w_adr  = r_k[BITWIDTH_ADR-1:0];
                end
                default: begin
                    w_we = 1'b0;
                    w_re = 1'b0;
                end
            endcase
        end else begin
            w_we = 1'b0;
            w_re = 1'b0;
        end
    end

    // Banked single-port RAM with a registered read port (contents are never reset)
    always_ff @(posedge i_clk_sys) begin
        if (w_we) begin
            r_mem[w_bank][w_adr] <= w_wdata;
        end else if (w_re) begin
            r_rd_data <= r_mem[w_bank][w_adr];
        end
    end

    // BIST sequencer together with the result, status and output-select registers
    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_k        <= K_ZERO;
            r_seed     <= {BITWIDTH_IN{1'b0}};
            r_inv      <= 1'b0;
            r_err_cnt  <= 16'h0000;
            r_rdy      <= 1'b1;
            r_dout     <= {BITWIDTH_SYS{1'b0}};
            r_dout_ram <= 1'b0;
            r_cmp_vld  <= 1'b0;
            r_exp      <= {BITWIDTH_IN{1'b0}};
        end else if (bus.i_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state    <= ST_FILL;
                        r_seed     <= w_din_word;
                        r_inv      <= (bus.i_mode == 2'b10);
                        r_err_cnt  <= 16'h0000;
                        r_k        <= K_ZERO;
                        r_cmp_vld  <= 1'b0;
                        r_rdy      <= 1'b0;
                        r_dout     <= w_dout;
                        r_dout_ram <= 1'b0;
                    end else if (w_re) begin
                        r_dout_ram <= 1'b1;
                    end
                end
                ST_FILL: begin
                    r_k <= r_k + K_ONE;
                    if (w_k_last) begin
                        r_state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    // The fault hook flips the expected LSB, so every injected cycle costs exactly one error
                    r_exp     <= f_pattern(r_inv, r_seed, r_k) ^ BITWIDTH_IN'(bus.i_fault_inj);
                    r_cmp_vld <= 1'b1;
                    r_k       <= r_k + K_ONE;
                    if (w_mismatch) begin
                        r_err_cnt <= f_sat_inc(r_err_cnt);
                    end
                    if (w_k_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_mismatch) begin
                        r_err_cnt <= f_sat_inc(r_err_cnt);
                    end
                    r_cmp_vld <= 1'b0;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    r_dout  <= BITWIDTH_SYS'(r_err_cnt);
                    r_rdy   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign w_dout          = r_dout_ram ? f_pad_word(r_rd_data) : r_dout;
    assign bus.o_data_out  = w_dout;
    assign bus.o_data_head = HEAD;
    assign bus.o_rdy       = r_rdy;
    assign bus.o_err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_skeleton_ram_bist.sv
// Self-checking bench for skeleton_ram_bist. It uses randomized direct traffic and BIST runs, and
// checks them against a word-array model of the RAM and a cycle-count model of the BIST.
module tb_skeleton_ram_bist;
    localparam int IN    = 12;
    localparam int SYS   = 16;
    localparam int HEADW = 30;
    localparam int ADR   = 6;
    localparam int BANKW = 2;
    localparam int WORDS = 256;
    localparam int BUSY  = 514;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_exp_err = 0;

    logic [IN-1:0] model_mem [WORDS];
    bit            model_vld [WORDS];

    skeleton_ram_bist_if #(.BITWIDTH_IN(IN), .BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEADW),
                           .BITWIDTH_ADR(ADR), .BITWIDTH_BANK(BANKW)) bus ();

    skeleton_ram_bist #(.BITWIDTH_IN(IN), .BITWIDTH_SYS(SYS), .BITWIDTH_HEAD(HEADW),
                        .BITWIDTH_ADR(ADR), .BITWIDTH_BANK(BANKW)) dut (
        .i_clk_sys (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.i_en = 1'b0; bus.i_trgg_start_calc = 1'b0; bus.i_mode = 2'b00; bus.i_rnw = 1'b0;
        bus.i_bank = '0; bus.i_adr = '0; bus.i_data_in = '0; bus.i_fault_inj = 1'b0;
    endtask

    // Expected BIST word for linear index k
    function automatic logic [IN-1:0] pat(input int mode, input int seed, input int k);
        int v;
        v = (seed + k) % 4096;
        if (mode == 2) v = 4095 - v;
        return IN'(v);
    endfunction

    task automatic dir_write(input int k, input logic [IN-1:0] w);
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b0;
        bus.i_mode = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        bus.i_rnw = 1'b1; bus.i_bank = BANKW'(k / 64); bus.i_adr = ADR'(k % 64);
        bus.i_data_in = {w, 4'($urandom)};
        step();
        model_mem[k] = w; model_vld[k] = 1'b1;
        bus.i_en = 1'b0;
    endtask

    task automatic dir_read(input int k, output logic [SYS-1:0] d);
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b0;
        bus.i_mode = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        bus.i_rnw = 1'b0; bus.i_bank = BANKW'(k / 64); bus.i_adr = ADR'(k % 64);
        bus.i_data_in = 16'($urandom);
        step();
        d = bus.o_data_out;
        bus.i_en = 1'b0;
    endtask

    // One full BIST run: style 0 = EN always high, 1 = EN toggling, 2 = EN random
    task automatic run_bist(input int mode, input int seed, input int style, input int fault_off,
                            output int low_cnt, output int exp_low, output int exp_err,
                            output logic [15:0] err_o, output logic [SYS-1:0] dout_o);
        int e;
        int n;
        bit en_now;
        bit in_win;
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b1; bus.i_mode = 2'(mode);
        bus.i_rnw = 1'($urandom); bus.i_data_in = {IN'(seed), 4'($urandom)}; bus.i_fault_inj = 1'b0;
        step();
        low_cnt = bus.o_rdy ? 0 : 1;
        exp_low = 0; exp_err = 0; e = 0;
        for (int cyc = 1; cyc <= 4000; cyc++) begin
            case (style)
                0: en_now = 1'b1;
                1: en_now = ((cyc % 2) == 0);
                default: en_now = 1'($urandom_range(0, 1));
            endcase
            n = e + 1;
            in_win = en_now && (fault_off >= 0) && (n >= 257 + fault_off) && (n < 267 + fault_off);
            if (in_win) begin
                bus.i_fault_inj = 1'b1;
                exp_err++;
            end else if (en_now && n >= 257 && n <= 512) begin
                bus.i_fault_inj = 1'b0;
            end else begin
                bus.i_fault_inj = 1'($urandom);
            end
            bus.i_en = en_now;
            bus.i_trgg_start_calc = ($urandom_range(0, 15) == 0);
            bus.i_mode = 2'($urandom); bus.i_rnw = 1'($urandom);
            bus.i_bank = BANKW'($urandom); bus.i_adr = ADR'($urandom); bus.i_data_in = 16'($urandom);
            step();
            if (en_now) e++;
            if (e == BUSY && exp_low == 0) exp_low = cyc;
            if (bus.o_rdy) break;
            low_cnt++;
        end
        err_o = bus.o_err_cnt;
        dout_o = bus.o_data_out;
        drive_idle();
        for (int k = 0; k < WORDS; k++) begin
            model_mem[k] = pat(mode, seed, k);
            model_vld[k] = 1'b1;
        end
        last_exp_err = exp_err;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        #13;
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b expected 1", bus.o_rdy); end
        n_cmp++; if (bus.o_err_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_err: got %h expected 0000", bus.o_err_cnt); end
        n_cmp++; if (bus.o_data_out !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h expected 0000", bus.o_data_out); end
        n_cmp++; if (bus.o_data_head !== {4'd3, 4'd2, 6'd6, 6'd6, 5'd12, 5'd12}) begin
            n_err++; $display("FAIL data_head: got %h expected %h", bus.o_data_head, {4'd3, 4'd2, 6'd6, 6'd6, 5'd12, 5'd12}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_direct();
        logic [SYS-1:0] d;
        logic [SYS-1:0] held;
        int k;
        int r;
        dir_write(1 * 64 + 5, 12'h123);
        dir_write(2 * 64 + 5, 12'hABC);
        dir_read(2 * 64 + 5, d);
        n_cmp++; if (d !== 16'hABC0) begin n_err++; $display("FAIL direct_b2a5: got %h expected ABC0", d); end
        dir_read(1 * 64 + 5, d);
        n_cmp++; if (d !== 16'h1230) begin n_err++; $display("FAIL direct_b1a5: got %h expected 1230", d); end
        held = d;
        dir_write(7, 12'h5A5);
        n_cmp++; if (bus.o_data_out !== held) begin n_err++; $display("FAIL hold_on_write: got %h expected %h", bus.o_data_out, held); end
        bus.i_en = 1'b0; bus.i_rnw = 1'b0; bus.i_bank = 2'd3; bus.i_adr = 6'd7;
        step();
        n_cmp++; if (bus.o_data_out !== held) begin n_err++; $display("FAIL hold_on_en0: got %h expected %h", bus.o_data_out, held); end
        for (int i = 0; i < 16; i++) begin
            k = $urandom_range(0, WORDS - 1);
            dir_write(k, IN'($urandom));
            r = $urandom_range(0, WORDS - 1);
            if (!model_vld[r]) r = k;
            dir_read(r, d);
            n_cmp++; if (d !== {model_mem[r], 4'h0}) begin n_err++; $display("FAIL direct_rand k=%0d: got %h expected %h", r, d, {model_mem[r], 4'h0}); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [SYS-1:0] d;
        int seed;
        seed = $urandom_range(0, 4095);
        dir_write(150, 12'h3C7);
        dir_write(100, 12'h8E1);
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b1; bus.i_mode = 2'b01; bus.i_rnw = 1'b0;
        bus.i_data_in = {IN'(seed), 4'h0};
        step();
        bus.i_trgg_start_calc = 1'b0;
        repeat (100) step();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL rst_fill_rdy: got %b expected 1", bus.o_rdy); end
        n_cmp++; if (bus.o_err_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_fill_err: got %h expected 0000", bus.o_err_cnt); end
        n_cmp++; if (bus.o_data_out !== 16'h0000) begin n_err++; $display("FAIL rst_fill_dout: got %h expected 0000", bus.o_data_out); end
        step();
        rst = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL rst_fill_stay_idle: got %b expected 1", bus.o_rdy); end
        for (int k = 0; k < 100; k++) begin
            model_mem[k] = pat(1, seed, k); model_vld[k] = 1'b1;
        end
        dir_read(99, d);
        n_cmp++; if (d !== {model_mem[99], 4'h0}) begin n_err++; $display("FAIL rst_fill_k99: got %h expected %h", d, {model_mem[99], 4'h0}); end
        dir_read(100, d);
        n_cmp++; if (d !== 16'h8E10) begin n_err++; $display("FAIL rst_fill_k100: got %h expected 8E10", d); end
        dir_read(150, d);
        n_cmp++; if (d !== 16'h3C70) begin n_err++; $display("FAIL rst_fill_k150: got %h expected 3C70", d); end
    endtask

    task automatic test_bist_incr();
        int low; int xlow; int xerr; logic [15:0] err; logic [SYS-1:0] dout; logic [SYS-1:0] d; int k;
        run_bist(1, 0, 0, -1, low, xlow, xerr, err, dout);
        n_cmp++; if (low !== BUSY) begin n_err++; $display("FAIL incr_busy: got %0d expected %0d", low, BUSY); end
        n_cmp++; if (err !== 16'h0000) begin n_err++; $display("FAIL incr_err: got %h expected 0000", err); end
        n_cmp++; if (dout !== 16'h0000) begin n_err++; $display("FAIL incr_dout: got %h expected 0000", dout); end
        dir_read(255, d);
        n_cmp++; if (d !== 16'h0FF0) begin n_err++; $display("FAIL incr_b3a63: got %h expected 0FF0", d); end
        for (int i = 0; i < 6; i++) begin
            k = $urandom_range(0, WORDS - 1);
            dir_read(k, d);
            n_cmp++; if (d !== {model_mem[k], 4'h0}) begin n_err++; $display("FAIL incr_rd k=%0d: got %h expected %h", k, d, {model_mem[k], 4'h0}); end
        end
    endtask

    task automatic test_bist_inv();
        int low; int xlow; int xerr; logic [15:0] err; logic [SYS-1:0] dout; logic [SYS-1:0] d;
        run_bist(2, 12'hFFE, 0, -1, low, xlow, xerr, err, dout);
        n_cmp++; if (err !== 16'h0000) begin n_err++; $display("FAIL inv_err: got %h expected 0000", err); end
        n_cmp++; if (low !== BUSY) begin n_err++; $display("FAIL inv_busy: got %0d expected %0d", low, BUSY); end
        dir_read(2, d);
        n_cmp++; if (d !== 16'hFFF0) begin n_err++; $display("FAIL inv_b0a2: got %h expected FFF0", d); end
        dir_read(200, d);
        n_cmp++; if (d !== {model_mem[200], 4'h0}) begin n_err++; $display("FAIL inv_k200: got %h expected %h", d, {model_mem[200], 4'h0}); end
    endtask

    task automatic test_fault();
        int low; int xlow; int xerr; logic [15:0] err; logic [SYS-1:0] dout;
        run_bist(1, $urandom_range(0, 4095), 0, $urandom_range(0, 246), low, xlow, xerr, err, dout);
        n_cmp++; if (err !== 16'd10) begin n_err++; $display("FAIL fault_err: got %0d expected 10", err); end
        n_cmp++; if (dout !== 16'h000A) begin n_err++; $display("FAIL fault_dout: got %h expected 000A", dout); end
        n_cmp++; if (low !== BUSY) begin n_err++; $display("FAIL fault_busy: got %0d expected %0d", low, BUSY); end
        run_bist(2, $urandom_range(0, 4095), 1, $urandom_range(0, 246), low, xlow, xerr, err, dout);
        n_cmp++; if (err !== 16'd10) begin n_err++; $display("FAIL fault_toggle_err: got %0d expected 10", err); end
        n_cmp++; if (dout !== 16'h000A) begin n_err++; $display("FAIL fault_toggle_dout: got %h expected 000A", dout); end
        n_cmp++; if (low !== xlow) begin n_err++; $display("FAIL fault_toggle_busy: got %0d expected %0d", low, xlow); end
    endtask

    task automatic test_random_bist();
        int low; int xlow; int xerr; logic [15:0] err; logic [SYS-1:0] dout; logic [SYS-1:0] d; int k; int off;
        for (int r = 0; r < 3; r++) begin
            off = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 246);
            run_bist($urandom_range(1, 2), $urandom_range(0, 4095), 2, off, low, xlow, xerr, err, dout);
            n_cmp++; if (err !== 16'(xerr)) begin n_err++; $display("FAIL rnd_err run%0d: got %0d expected %0d", r, err, xerr); end
            n_cmp++; if (dout !== SYS'(xerr)) begin n_err++; $display("FAIL rnd_dout run%0d: got %h expected %h", r, dout, SYS'(xerr)); end
            n_cmp++; if (low !== xlow) begin n_err++; $display("FAIL rnd_busy run%0d: got %0d expected %0d", r, low, xlow); end
            for (int i = 0; i < 4; i++) begin
                k = $urandom_range(0, WORDS - 1);
                dir_read(k, d);
                n_cmp++; if (d !== {model_mem[k], 4'h0}) begin n_err++; $display("FAIL rnd_rd k=%0d: got %h expected %h", k, d, {model_mem[k], 4'h0}); end
            end
        end
    endtask

    task automatic test_ignore_triggers();
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b1; bus.i_mode = 2'b00; bus.i_rnw = 1'b0;
        step();
        bus.i_trgg_start_calc = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL trig_mode00_rdy: got %b expected 1", bus.o_rdy); end
        n_cmp++; if (bus.o_err_cnt !== 16'(last_exp_err)) begin n_err++; $display("FAIL trig_mode00_err: got %0d expected %0d", bus.o_err_cnt, last_exp_err); end
        bus.i_trgg_start_calc = 1'b1; bus.i_mode = 2'b11;
        step();
        bus.i_trgg_start_calc = 1'b0;
        step();
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL trig_mode11_rdy: got %b expected 1", bus.o_rdy); end
        bus.i_en = 1'b0; bus.i_trgg_start_calc = 1'b1; bus.i_mode = 2'b01;
        step();
        bus.i_en = 1'b1; bus.i_trgg_start_calc = 1'b0;
        repeat (2) step();
        n_cmp++; if (bus.o_rdy !== 1'b1) begin n_err++; $display("FAIL trig_en0_rdy: got %b expected 1", bus.o_rdy); end
        n_cmp++; if (bus.o_err_cnt !== 16'(last_exp_err)) begin n_err++; $display("FAIL trig_en0_err: got %0d expected %0d", bus.o_err_cnt, last_exp_err); end
        drive_idle();
    endtask

    initial begin
        for (int k = 0; k < WORDS; k++) model_vld[k] = 1'b0;
        test_reset();
        test_direct();
        test_reset_mid_fill();
        test_bist_incr();
        test_bist_inv();
        test_fault();
        test_random_bist();
        test_ignore_triggers();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
